// File: rtl/matrix_serial_tx.sv
// matrix_serial_tx: holds one frame of N_ELEM elements (a 4x4 row-major operand matrix at
// defaults) and shifts it out over a three-wire serial link (data, clock, frame sync).
//
// Ports:
//   clk, rst_n      - sole clock (rising edge), asynchronous active-low reset
//   wr_en/addr/data - element write port, honoured only while idle
//   send            - start transmitting the buffered frame (ignored while a frame is in flight)
//   busy            - high for every cycle of the frame
//   done            - one-cycle pulse after the last bit period
//   ser_data        - serial data, element 0 first, MSB first
//   ser_clk         - serial clock, low for the first half of each bit period
//   ser_frame_sync  - frame marker, high for the whole frame
module matrix_serial_tx #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned N_ELEM   = 16,
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(N_ELEM)-1:0] wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      send,
  output logic                      busy,
  output logic                      done,
  output logic                      ser_data,
  output logic                      ser_clk,
  output logic                      ser_frame_sync
);

  localparam int unsigned AddrW = $clog2(N_ELEM);
  localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DivW  = $clog2(SCLK_DIV);

  localparam logic [DivW-1:0]  DivLast  = DivW'(SCLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(SCLK_DIV / 2);
  localparam logic [AddrW-1:0] ElemLast = AddrW'(N_ELEM - 1);
  localparam logic [BitW-1:0]  BitMsb   = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [N_ELEM];
  logic [DivW-1:0]   div_q, div_d;    // clk cycle within the bit period
  logic [BitW-1:0]   bit_q, bit_d;    // bit within the element, counts down from MSB
  logic [AddrW-1:0]  elem_q, elem_d;  // element within the frame
  logic              wr_ok;

  // Outputs are decoded purely from registers, so the asynchronous reset clears them at once.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    elem_d         = elem_q;
    wr_ok          = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    ser_data       = 1'b0;
    ser_clk        = 1'b0;
    ser_frame_sync = 1'b0;

    unique case (state_q)
      StIdle: begin
        wr_ok = wr_en;
        if (send) begin
          state_d = StShift;
          div_d   = '0;
          bit_d   = BitMsb;
          elem_d  = '0;
        end
      end
      StShift: begin
        busy           = 1'b1;
        ser_frame_sync = 1'b1;
        ser_clk        = (div_q >= DivHalf);
        // Buffer is write-locked here, so data only moves when the counters step.
        ser_data       = mem_q[elem_q][bit_q];
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == '0) begin
            bit_d = BitMsb;
            if (elem_q == ElemLast) begin
              state_d = StDone;
            end else begin
              elem_d = elem_q + 1'b1;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
        div_d   = '0;
        bit_d   = '0;
        elem_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      elem_q  <= elem_d;
    end
  end

  // A write in the same cycle as send lands before the first SHIFT cycle reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ELEM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_serial_tx.sv
module tb_matrix_serial_tx;

  localparam int DW    = 8;
  localparam int NE    = 16;
  localparam int DIV   = 4;
  localparam int FRAME = NE * DW * DIV;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       send    = 1'b0;
  logic       busy, done, ser_data, ser_clk, ser_frame_sync;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model [NE];
  logic [7:0] exp_q [$];

  matrix_serial_tx #(
    .DATA_W  (DW),
    .N_ELEM  (NE),
    .SCLK_DIV(DIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .send          (send),
    .busy          (busy),
    .done          (done),
    .ser_data      (ser_data),
    .ser_clk       (ser_clk),
    .ser_frame_sync(ser_frame_sync)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle.
  task automatic write_elem(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called at a negedge while idle; the frame expected is the model at acceptance.
  task automatic start_frame();
    send = 1'b1;
    for (int k = 0; k < NE; k++) exp_q.push_back(model[k]);
  endtask

  // mode 0: plain frame, 1: write attempt mid-frame, 2: send mid-frame, 3: reset mid-frame
  task automatic run_frame(input int mode);
    int         cyc       = 0;
    int         terr      = 0;
    int         nbits     = 0;
    logic [7:0] sh        = '0;
    logic       prev_clk  = 1'b0;
    logic       prev_data = 1'b0;
    logic [7:0] e;
    logic       exp_first;
    exp_first = model[0][DW-1];
    @(negedge clk);
    send  = 1'b0;
    wr_en = 1'b0;
    check("busy_start", busy, 1);
    check("first_sclk", ser_clk, 0);
    check("first_bit", ser_data, exp_first);
    while (busy === 1'b1 && cyc < 4 * FRAME) begin
      if (ser_clk !== ((cyc % DIV) >= DIV / 2)) terr++;
      if (ser_frame_sync !== 1'b1 || done !== 1'b0) terr++;
      if ((cyc % DIV) != 0 && ser_data !== prev_data) terr++;
      if (ser_clk && !prev_clk) begin
        sh = {sh[6:0], ser_data};
        nbits++;
        if (nbits % DW == 0) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", sh, e);
          end
        end
      end
      prev_clk  = ser_clk;
      prev_data = ser_data;
      if (mode == 1 && cyc == 100) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
      end
      if (mode == 1 && cyc == 101) wr_en = 1'b0;
      if (mode == 2 && cyc == 50) send = 1'b1;
      if (mode == 2 && cyc == 51) send = 1'b0;
      if (mode == 3 && cyc == 202) begin
        #1 rst_n = 1'b0;
        #1 check("async_rst_out", {busy, done, ser_data, ser_clk, ser_frame_sync}, 0);
        check("abort_partial_bits", nbits, 51);
        check("abort_timing", terr, 0);
        exp_q.delete();
        for (int k = 0; k < NE; k++) model[k] = 8'h00;
        repeat (3) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0 || ser_clk !== 1'b0) terr++;
        end
        check("abort_no_done", terr, 0);
        return;
      end
      cyc++;
      @(negedge clk);
    end
    check("busy_cycles", cyc, FRAME);
    check("frame_timing", terr, 0);
    check("done_pulse", {done, busy, ser_frame_sync, ser_clk, ser_data}, 5'b10000);
    check("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", {done, busy}, 0);
  endtask

  initial begin
    int seen;
    for (int k = 0; k < NE; k++) model[k] = 8'h00;
    #1 check("reset_outputs", {busy, done, ser_data, ser_clk, ser_frame_sync}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NE; k++) write_elem(k, 8'(k + 1));
    start_frame(); run_frame(0);

    // write during the frame must not reach the buffer
    start_frame(); run_frame(1);
    start_frame(); run_frame(0);

    // send during the frame is dropped, not queued
    start_frame(); run_frame(2);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || ser_frame_sync) seen++;
    end
    check("no_second_frame", seen, 0);

    // write and send in the same cycle, then back-to-back send right after done
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'hA5; model[15] = 8'hA5;
    start_frame(); run_frame(0);
    start_frame(); run_frame(0);

    // reset mid-frame clears the buffer; send on the first edge after release
    start_frame(); run_frame(3);
    rst_n = 1'b1;
    start_frame(); run_frame(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
